// File: rtl/nic_issue_arbiter.sv
// nic_issue_arbiter: round-robin owner of the single MNIC issue port.
// One requester at a time is granted, its read or write is issued to the
// MNIC, and the grant is held until the MNIC reports completion. Requesters
// that trip an MNIC anomaly or the hold watchdog are masked for a while.

// Per-requester quarantine timer: a load (re)starts it, and the requester
// stays masked while the count is nonzero.
module nic_quar_lane #(
  parameter int QUAR_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic quarantined
);
  localparam int QW = $clog2(QUAR_CYCLES + 1);

  logic [QW-1:0] cnt;

  // Load wins over the decrement, so a repeat event restarts a running count.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= QW'(QUAR_CYCLES);
    else if (cnt != '0)   cnt <= cnt - QW'(1);
  end

  assign quarantined = (cnt != '0);
endmodule

module nic_issue_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int QUAR_CYCLES = 256,
  parameter int MAX_HOLD    = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_rd,
  input  logic [NREQ-1:0] req_wr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_rw,
  output logic            issue_read,
  output logic            issue_write,
  input  logic            got_issue_read,
  input  logic            got_issue_write,
  input  logic            nic_busy,
  input  logic [1:0]      anomaly,
  output logic            done,
  output logic [NREQ-1:0] quarantined,
  output logic            timeout_err
);
  localparam int WDW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  ptr, ptr_d, pick_id, grant_id_d;
  logic            pick_found;
  int              pick_idx;
  logic [WDW-1:0]  wd, wd_d;
  logic [1:0]      anomaly_q;
  logic [NREQ-1:0] eligible, quar_load, grant_d;
  logic            grant_rw_d, issue_read_d, issue_write_d, done_d, timeout_d;
  logic            holding, got_match, wd_expire, anom_hit;

  assign eligible  = (req_rd | req_wr) & ~quarantined;
  assign holding   = (state == ISSUE) || (state == WAIT_DONE);
  assign got_match = grant_rw ? got_issue_write : got_issue_read;
  // Expire on the edge where the hold counter reaches MAX_HOLD-1, so
  // timeout_err is visible MAX_HOLD-1 cycles after the grant appears.
  assign wd_expire = holding && (wd == WDW'(MAX_HOLD - 2));
  // Only rising anomaly bits count; a stuck level is attributed once.
  assign anom_hit  = (state != IDLE) && ((anomaly & ~anomaly_q) != 2'b00);

  // Round-robin search from ptr+1; scanning far-to-near leaves the nearest hit.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      pick_idx = (int'(ptr) + k) % NREQ;
      if (eligible[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(pick_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state: watchdog expiry overrides any handshake progress.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (pick_found && !nic_busy) state_d = ISSUE;
      ISSUE:     if (wd_expire) state_d = RELEASE;
                 else if (got_match) state_d = WAIT_DONE;
      WAIT_DONE: if (wd_expire || (!got_match && !nic_busy)) state_d = RELEASE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    grant_d       = grant;
    grant_id_d    = grant_id;
    grant_rw_d    = grant_rw;
    ptr_d         = ptr;
    wd_d          = wd;
    issue_read_d  = 1'b0;
    issue_write_d = 1'b0;
    done_d        = 1'b0;
    timeout_d     = wd_expire;
    if (state == IDLE && state_d == ISSUE) begin
      grant_d          = '0;
      grant_d[pick_id] = 1'b1;
      grant_id_d       = pick_id;
      grant_rw_d       = req_wr[pick_id];
      wd_d             = '0;
    end
    if (holding) wd_d = wd + WDW'(1);
    if (state_d == ISSUE) begin
      issue_write_d = grant_rw_d;
      issue_read_d  = ~grant_rw_d;
    end
    if (holding && state_d == RELEASE) begin
      grant_d = '0;
      done_d  = 1'b1;
      ptr_d   = grant_id;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_id    <= '0;
      grant_rw    <= 1'b0;
      issue_read  <= 1'b0;
      issue_write <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= IDW'(NREQ - 1);
      wd          <= '0;
      anomaly_q   <= '0;
    end else begin
      grant       <= grant_d;
      grant_id    <= grant_id_d;
      grant_rw    <= grant_rw_d;
      issue_read  <= issue_read_d;
      issue_write <= issue_write_d;
      done        <= done_d;
      timeout_err <= timeout_d;
      ptr         <= ptr_d;
      wd          <= wd_d;
      anomaly_q   <= anomaly;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign quar_load[i] = (wd_expire || anom_hit) && (grant_id == IDW'(i));
    nic_quar_lane #(.QUAR_CYCLES(QUAR_CYCLES)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load        (quar_load[i]),
      .quarantined (quarantined[i])
    );
  end
endmodule

// File: tb/tb_nic_issue_arbiter.sv
// Bench for nic_issue_arbiter: directed scenarios, a reactive MNIC responder,
// a transaction-level reference model compared every cycle, and literal
// expectations for the key timing points.
module tb_nic_issue_arbiter;
  localparam int NREQ = 4, IDW = 2, QC = 256, MH = 1024;

  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_rd = '0, req_wr = '0;
  logic [NREQ-1:0] grant, quarantined;
  logic [IDW-1:0]  grant_id;
  logic grant_rw, issue_read, issue_write, done, timeout_err;
  logic got_issue_read, got_issue_write, nic_busy;
  logic [1:0] anomaly = 2'b00;

  nic_issue_arbiter #(.NREQ(NREQ), .IDW(IDW), .QUAR_CYCLES(QC), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
    .grant(grant), .grant_id(grant_id), .grant_rw(grant_rw),
    .issue_read(issue_read), .issue_write(issue_write),
    .got_issue_read(got_issue_read), .got_issue_write(got_issue_write),
    .nic_busy(nic_busy), .anomaly(anomaly), .done(done),
    .quarantined(quarantined), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, q2_cycles = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (quarantined[2] === 1'b1) q2_cycles <= q2_cycles + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // MNIC responder: ack ack_dly cycles after seeing an issue, hold
  // got/busy for hold cycles, then drop both.
  int ack_dly = 1, hold = 4, rphase = 0, rcnt = 0;
  bit rsp_never = 1'b0, rwr = 1'b0;
  initial begin
    got_issue_read = 1'b0; got_issue_write = 1'b0; nic_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rphase)
        0: if ((issue_read || issue_write) && !rsp_never) begin
             rwr = issue_write; rcnt = ack_dly; rphase = 1;
           end
        1: begin
             rcnt--;
             if (rcnt <= 0) begin
               if (rwr) got_issue_write = 1'b1; else got_issue_read = 1'b1;
               nic_busy = 1'b1; rcnt = hold; rphase = 2;
             end
           end
        default: begin
             rcnt--;
             if (rcnt <= 0) begin
               got_issue_read = 1'b0; got_issue_write = 1'b0; nic_busy = 1'b0; rphase = 0;
             end
           end
      endcase
    end
  end

  // Reference model: tracks the transaction owner, whether the MNIC has
  // acknowledged, the release cycle, and each requester's quarantine end
  // as an absolute cycle number.
  int  mc = 0, m_own, m_gid, m_ptr, m_t0, best, ci;
  bit  m_rel, m_to, m_acked, m_rw, newa, mgot;
  int  q_end[NREQ];
  logic [1:0] m_anq;
  logic [NREQ-1:0] eg, eq;

  task automatic m_reset();
    m_own = -1; m_gid = 0; m_ptr = NREQ - 1; m_t0 = 0;
    m_rel = 0; m_to = 0; m_acked = 0; m_rw = 0; m_anq = 2'b00;
    for (int i = 0; i < NREQ; i++) q_end[i] = -1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      eg = '0;
      if (m_own >= 0 && !m_rel) eg[m_own] = 1'b1;
      for (int i = 0; i < NREQ; i++) eq[i] = (mc <= q_end[i]);
      chk("grant", grant, eg);
      chk("grant_id", grant_id, m_gid);
      chk("grant_rw", grant_rw, m_rw);
      chk("issue_read", issue_read, (m_own >= 0 && !m_rel && !m_acked && !m_rw));
      chk("issue_write", issue_write, (m_own >= 0 && !m_rel && !m_acked && m_rw));
      chk("done", done, m_rel);
      chk("timeout_err", timeout_err, m_to);
      chk("quarantined", quarantined, eq);
      // advance one cycle using the inputs the next edge will sample
      if (rst) m_reset();
      else begin
        newa = ((anomaly & ~m_anq) != 2'b00);
        mgot = m_rw ? got_issue_write : got_issue_read;
        if (m_rel) begin
          if (newa) q_end[m_gid] = mc + QC;
          m_rel = 0; m_to = 0; m_own = -1;
        end else if (m_own >= 0) begin
          if (newa) q_end[m_gid] = mc + QC;
          if (mc - m_t0 == MH - 2) begin
            q_end[m_gid] = mc + QC; m_to = 1; m_rel = 1; m_ptr = m_gid;
          end else if (!m_acked) begin
            if (mgot) m_acked = 1;
          end else if (!mgot && !nic_busy) begin
            m_rel = 1; m_ptr = m_gid;
          end
        end else if (!nic_busy) begin
          best = -1;
          for (int d = 1; d <= NREQ; d++) begin
            ci = (m_ptr + d) % NREQ;
            if (best < 0 && (req_rd[ci] || req_wr[ci]) && !(mc <= q_end[ci])) best = ci;
          end
          if (best >= 0) begin
            m_own = best; m_gid = best; m_rw = req_wr[best]; m_acked = 0; m_t0 = mc + 1;
          end
        end
        m_anq = anomaly;
      end
      mc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic wait_grant(input string name, input int maxc);
    bit ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (grant != '0) begin ok = 1'b1; break; end
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    chk(name, ok, 1'b1);
  endtask

  int exp_ord[5] = '{0, 1, 2, 3, 0};
  int qs, gc;
  bit ok;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single write: req at c0
    req_wr = 4'b0001;
    @(negedge clk); chk("w_c0_grant", grant, 4'b0000);
    @(negedge clk); chk("w_c1_grant", grant, 4'b0001); chk("w_c1_iwr", issue_write, 1'b1);
    @(negedge clk); chk("w_c2_iwr", issue_write, 1'b1);
    @(negedge clk); chk("w_c3_iwr", issue_write, 1'b0); chk("w_c3_grant", grant, 4'b0001);
    repeat (3) @(negedge clk); chk("w_c6_done", done, 1'b0);
    @(negedge clk); chk("w_c7_done", done, 1'b1); chk("w_c7_grant", grant, 4'b0000);
    tick(); req_wr = '0;
    repeat (3) tick();

    // fairness
    do_reset();
    req_rd = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done("fair_done_seen", 60);
      chk("fair_order", grant_id, exp_ord[k]);
      chk("fair_rw", grant_rw, 1'b0);
    end
    tick(); req_rd = '0;
    repeat (3) tick();

    // same requester read+write: write wins first
    do_reset();
    req_rd = 4'b0010; req_wr = 4'b0010;
    wait_grant("rw_grant1_seen", 10);
    chk("rw_g1_id", grant_id, 2'd1); chk("rw_g1_rw", grant_rw, 1'b1);
    chk("rw_g1_iwr", issue_write, 1'b1); chk("rw_g1_ird", issue_read, 1'b0);
    wait_done("rw_done1_seen", 30);
    tick(); req_wr = '0;
    wait_grant("rw_grant2_seen", 10);
    chk("rw_g2_grant", grant, 4'b0010); chk("rw_g2_rw", grant_rw, 1'b0);
    chk("rw_g2_ird", issue_read, 1'b1);
    wait_done("rw_done2_seen", 30);
    tick(); req_rd = '0;
    repeat (3) tick();

    // anomaly during requester 2's WAIT_DONE
    do_reset();
    req_rd = 4'b0100;
    wait_grant("an_grant_seen", 10);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (issue_read == 1'b0) begin ok = 1'b1; break; end
    end
    chk("an_ack_seen", ok, 1'b1);
    tick(); anomaly = 2'b01;
    @(negedge clk); chk("an_q_before", quarantined[2], 1'b0);
    @(negedge clk); chk("an_q_after", quarantined[2], 1'b1); qs = cyc;
    wait_done("an_done_seen", 30);
    tick(); req_rd = 4'b1101;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (grant == 4'b0100) begin ok = 1'b1; break; end
    end
    chk("an_regrant_seen", ok, 1'b1);
    chk("an_regrant_after_expiry", (cyc >= qs + QC), 1'b1);
    wait_done("an_done2_seen", 30);
    tick(); req_rd = '0;
    repeat (4) tick();
    chk("an_q_length", q2_cycles, QC);
    anomaly = 2'b00;
    repeat (2) tick();

    // watchdog: never acknowledged
    do_reset();
    rsp_never = 1'b1;
    req_rd = 4'b1000;
    wait_grant("wd_grant_seen", 10); gc = cyc;
    ok = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin ok = 1'b1; break; end
    end
    chk("wd_timeout_seen", ok, 1'b1);
    chk("wd_delay", cyc - gc, MH - 1);
    chk("wd_ird", issue_read, 1'b0); chk("wd_done", done, 1'b1);
    chk("wd_quar", quarantined[3], 1'b1);
    @(negedge clk); chk("wd_pulse_one_cycle", timeout_err, 1'b0);
    tick(); req_rd = '0;
    repeat (2) tick();

    // reset mid-ISSUE (requester 3 still quarantined beforehand)
    req_rd = 4'b0100;
    wait_grant("rs_grant_seen", 10);
    chk("rs_pre_id", grant_id, 2'd2);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; rsp_never = 1'b0; req_rd = 4'b0101;
    @(negedge clk);
    chk("rs_grant", grant, 4'b0000); chk("rs_ird", issue_read, 1'b0);
    chk("rs_iwr", issue_write, 1'b0); chk("rs_quar", quarantined, 4'b0000);
    wait_grant("rs_grant2_seen", 10);
    chk("rs_first_id", grant_id, 2'd0);
    wait_done("rs_done_seen", 30);
    tick(); req_rd = '0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
